random_sampler: RTL and testbench
=================================

# random_sampler

Consumer side of the free-running random counters: captures a `Random_Counter` output value on request and range-reduces it to `0..RANGE-1` by iterative subtraction. The result is presented with a valid/ack handshake. It sits between the counter bank and the rectangle/tone generators, one instance per random quantity (X, Y, width, height, colour, pitch).

## Interface

**Parameters**
- `WIDTH`, default 8: counter MSB index; the sample is `WIDTH+1` bits, the same width as the counter output.
- `RANGE`, default 200: exclusive upper bound of the result.
  - Legal range is `1 <= RANGE <= 2^(WIDTH+1)`.
  - Out-of-range values are a configuration error, behaviour undefined.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `cnt_in`, in, `WIDTH+1`: live counter value to sample.
- `req`, in, 1: sample request; acted on only in IDLE, or in HOLD together with `ack`.
- `ack`, in, 1: consumer has taken `value`.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `valid`, out, 1: `value` holds a reduced result.
- `value`, out, `WIDTH+1`: reduced result, always `< RANGE` while `valid`.

## Operation

**Registers**
- `state` ∈ {IDLE, REDUCE, HOLD}.
- `work` and `value`, both `WIDTH+1` bits.
- All outputs are registered.

**IDLE**
- `busy=0`, `valid=0`.
- On `req=1`: `work <= cnt_in` (whitened, see Configuration), go to REDUCE.

**REDUCE**
- `busy=1`; `req` and `ack` are ignored.
- If `work >= RANGE`: `work <= work - RANGE` and stay in REDUCE. The compare and subtract are unsigned, full `WIDTH+1` bits, and cannot underflow.
- Else: `value <= work`, `valid <= 1`, go to HOLD.

**HOLD**
- `busy=1`, `valid=1`; `value` is stable.
- On `ack=1, req=0`: `valid <= 0`, go to IDLE.
- On `ack=1, req=1`: `valid <= 0`, `work <= cnt_in`, go to REDUCE (back-to-back sample).
- On `ack=0`: hold indefinitely, even if `req=1`.

**Boundary cases**
- If `RANGE = 2^(WIDTH+1)`, no subtraction ever occurs.
- If `RANGE = 1`, the result is always 0.
- `value` keeps its last result after `ack`; only `valid` drops.

**Reset**
- `rst` at any edge, including mid-REDUCE or mid-HOLD, forces: `state=IDLE`, `work=0`, `value=0`, `valid=0`, `busy=0`.
- Any pending request is discarded.

## Timing

- A `req` sampled at edge N in IDLE gives `busy=1` after edge N.
- With `k = floor(sample / RANGE)`, `valid=1` appears after edge N+1+k.
  - Latency is `2+k` cycles from `req` assertion to the first `valid` cycle.
- Worst-case `k = floor((2^(WIDTH+1)-1) / RANGE)`.
- An `ack` sampled at edge M clears `valid` after edge M.
  - If `req` is also high at edge M, the new sample is taken at that same edge M.
- `cnt_in` is sampled exactly once per request. Later changes have no effect.

## Configuration

Macro `RANDOM_SAMPLER_WHITEN_EN`:

- **Defined:** a 16-bit Fibonacci LFSR is compiled in.
  - Seed `16'hACE1` on `rst`.
  - Shifts left every clock in every state.
  - Feedback is `l[15]^l[13]^l[12]^l[10]`, shifted into bit 0.
  - The captured sample is `cnt_in ^ l[WIDTH:0]`, using the LFSR value before that edge's shift.
  - This decorrelates samples when `req` timing is periodic (e.g. once per frame).
  - Requires `WIDTH+1 <= 16`.
- **Not defined:** no LFSR logic; the captured sample is `cnt_in` directly.
- Handshake and timing are identical in both builds.

## Test plan

Defaults `WIDTH=8`, `RANGE=200`, macro undefined unless stated.

1. `cnt_in=150`, 1-cycle `req` at edge N → `busy=1` after N; `valid=1`, `value=150` after N+1; holds until `ack`; `ack` at edge M → `valid=0`, `busy=0` after M, `value` stays 150.
2. `cnt_in=511` → `work` goes 311 then 111; `valid=1`, `value=111` after N+3. Repeat with `cnt_in=199` → `value=199`, `k=0`; and with `cnt_in=200` → `value=0`, `k=1`.
3. `req` pulsed during REDUCE, and `req` held without `ack` during HOLD → ignored: one result only, `value` unchanged, no extra sample.
4. `ack` and `req` together in HOLD with `cnt_in=420` → `valid` drops for exactly the cycles in REDUCE; then `value=20`, `valid=1`, after 2 REDUCE cycles.
5. `rst` asserted one cycle into REDUCE with `cnt_in=511` → next cycle all outputs 0 and state IDLE; a fresh `req` with `cnt_in=5` → `value=5` after `req` edge +1.
6. `RANDOM_SAMPLER_WHITEN_EN` defined, `req` at the first edge after `rst` release, `cnt_in=0` → `value = 16'hACE1[8:0] mod 200 = 225 - 200 = 25`; 1000 random requests → all `value < 200`, no `valid` without a prior `req`.

Source files
------------

// File: rtl/random_sampler.sv
//------------------------------------------------------------------------------
// Module   : random_sampler
// Brief    : Captures a free-running counter value on request and reduces it
//            to 0..RANGE-1 by repeated subtraction; valid/ack result handshake.
//            Optional input whitening LFSR under RANDOM_SAMPLER_WHITEN_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module random_sampler #(
   parameter int WIDTH = 8,
   parameter int RANGE = 200
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [WIDTH:0] cnt_in,
   input  logic           req,
   input  logic           ack,
   output logic           busy,
   output logic           valid,
   output logic [WIDTH:0] value
);

   // RANGE may equal 2^(WIDTH+1), so the compare needs one extra bit.
   localparam logic [WIDTH+1:0] c_RANGE_X = (WIDTH+2)'(RANGE);
   localparam logic [WIDTH:0]   c_RANGE_N = c_RANGE_X[WIDTH:0];

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REDUCE = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t         r_state;
   logic [WIDTH:0] r_work;
   logic [WIDTH:0] w_sample;
   logic           w_ge;

`ifdef RANDOM_SAMPLER_WHITEN_EN
   logic [15:0] r_lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_sample = cnt_in ^ r_lfsr[WIDTH:0];
`else
   assign w_sample = cnt_in;
`endif

   assign w_ge = ({1'b0, r_work} >= c_RANGE_X);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_work  <= '0;
         value   <= '0;
         valid   <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req) begin
                  r_work  <= w_sample;
                  r_state <= S_REDUCE;
                  busy    <= 1'b1;
               end
            end
            S_REDUCE: begin
               if (w_ge) begin
                  r_work <= r_work - c_RANGE_N;
               end else begin
                  value   <= r_work;
                  valid   <= 1'b1;
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               // req alone is ignored here; only ack releases the result
               if (ack) begin
                  valid <= 1'b0;
                  if (req) begin
                     r_work  <= w_sample;
                     r_state <= S_REDUCE;
                  end else begin
                     r_state <= S_IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               valid   <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_random_sampler.sv
//------------------------------------------------------------------------------
// Module   : tb_random_sampler
// Brief    : Self-checking bench for random_sampler (directed + random steps).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_random_sampler;

   localparam int WIDTH = 8;
   localparam int RANGE = 200;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [WIDTH:0] cnt_in = '0;
   logic           req = 1'b0;
   logic           ack = 1'b0;
   logic           busy;
   logic           valid;
   logic [WIDTH:0] value;

   int n_assert = 0;
   int n_fail   = 0;
   int last_val = 0;

   random_sampler #(.WIDTH(WIDTH), .RANGE(RANGE)) dut (
      .clk    (clk),
      .rst    (rst),
      .cnt_in (cnt_in),
      .req    (req),
      .ack    (ack),
      .busy   (busy),
      .valid  (valid),
      .value  (value)
   );

   always #5 clk = ~clk;

   // Whitening source as described: seeded on reset, steps every clock.
   logic [15:0] lfsr_m = 16'hACE1;
   always @(posedge clk) begin
      if (rst) lfsr_m <= 16'hACE1;
      else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sample_of(input int cnt);
      int s;
      s = cnt;
`ifdef RANDOM_SAMPLER_WHITEN_EN
      s = s ^ int'(lfsr_m[WIDTH:0]);
`endif
      return s;
   endfunction

   // Issue a request at the next edge (optionally with ack, for back-to-back),
   // then follow the expected reduction latency with req toggled randomly.
   task automatic launch(input int cnt, input bit with_ack, input bit noisy);
      int s, k;
      cnt_in = cnt[WIDTH:0];
      s      = sample_of(cnt);
      k      = s / RANGE;
      req    = 1'b1;
      ack    = with_ack;
      tick();
      req = 1'b0;
      ack = 1'b0;
      check("start_busy", busy, 1);
      check("start_valid", valid, 0);
      for (int i = 0; i < k; i++) begin
         if (noisy) begin
            req    = $urandom_range(0, 1) == 1;
            cnt_in = $urandom_range(0, 511);
         end
         tick();
         check("reduce_valid", valid, 0);
      end
      if (noisy) req = $urandom_range(0, 1) == 1;
      tick();
      req = 1'b0;
      check("result_valid", valid, 1);
      check("result_value", value, s % RANGE);
      last_val = s % RANGE;
   endtask

   task automatic release_ack();
      ack = 1'b1;
      req = 1'b0;
      tick();
      ack = 1'b0;
      check("ack_valid", valid, 0);
      check("ack_busy", busy, 0);
      check("ack_value_kept", value, last_val);
   endtask

   initial begin
      rst = 1'b1;
      tick();
      tick();
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_value", value, 0);
      rst = 1'b0;

`ifdef RANDOM_SAMPLER_WHITEN_EN
      launch(0, 1'b0, 1'b0);
      check("whiten_first", value, 25);
      release_ack();
`endif

      // Idle without request: nothing appears
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_no_valid", valid, 0);
         check("idle_no_busy", busy, 0);
      end

      // Small value, no subtraction; result holds until ack
      launch(150, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cnt_in = 9'(i * 77);
         tick();
         check("hold_valid", valid, 1);
         check("hold_value", value, last_val);
      end
      release_ack();

      // Multi-step and boundary reductions
      launch(511, 1'b0, 1'b0);
      release_ack();
      launch(199, 1'b0, 1'b0);
      release_ack();
      launch(200, 1'b0, 1'b0);
      release_ack();

      // req noise during REDUCE, then req held without ack in HOLD
      launch(511, 1'b0, 1'b1);
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cnt_in = 9'd5;
         tick();
         check("hold_req_valid", valid, 1);
         check("hold_req_value", value, last_val);
         check("hold_req_busy", busy, 1);
      end
      req = 1'b0;
      release_ack();

      // Back-to-back: ack+req in HOLD starts a new sample at the same edge
      launch(37, 1'b0, 1'b0);
      launch(420, 1'b1, 1'b0);
      release_ack();

      // Reset in the middle of a reduction
      cnt_in = 9'd511;
      req    = 1'b1;
      tick();
      req = 1'b0;
      check("pre_rst_busy", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_value", value, 0);
      tick();
      check("midrst_idle", busy, 0);
      launch(5, 1'b0, 1'b0);
      release_ack();

      // Random traffic: random hold times, optional back-to-back requests
      for (int n = 0; n < 300; n++) begin
         launch(int'($urandom_range(0, 511)), 1'b0, 1'b1);
         check("rand_range", int'(value) < RANGE, 1);
         for (int w = int'($urandom_range(0, 2)); w > 0; w--) begin
            req = $urandom_range(0, 1) == 1;
            tick();
            check("rand_hold", valid, 1);
         end
         req = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            launch(int'($urandom_range(0, 511)), 1'b1, 1'b0);
         end
         release_ack();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
